lcd_bus_phy: RTL
================

Name: lcd_bus_phy

Overview:
- Physical 8080-style parallel bus engine for the 16-bit LCD. It is the terminating end of the mux-to-interface command channel.
- Accepts single-word write and read requests (we/wr/rs/data/id_fm/read_color) and generates the cs_n/rs/wr_n/rd_n strobes with programmable timing.
- Drives and receives the bidirectional data bus, then returns busy, write-done, color-done and read data to the command side.

Parameters:
- WR_LOW_CYC, 2: pclk cycles wr_n held low per write; range 1..255.
- WR_HIGH_CYC, 2: pclk cycles wr_n held high after the low phase; range 1..255.
- RD_LOW_ID, 2: rd_n low cycles per word for an ID read (id_fm=0); range 1..255.
- RD_LOW_FM, 8: rd_n low cycles per word for a frame-memory read (id_fm=1); range 1..255.
- RD_HIGH_CYC, 2: rd_n high cycles after each read word; range 1..255.

Ports:
- pclk in 1: clock.
- rst_n in 1: synchronous active-low reset.
- data_i in 16: write word or command.
- we_i in 1: request strobe; accepted only when busy_o=0.
- wr_i in 1: 1 = write transaction, 0 = read transaction.
- rs_i in 1: 0 = command, 1 = data; driven onto lcd_rs.
- id_fm_i in 1: read type; 0 = ID read, 1 = frame-memory read.
- read_color_i in 1: 1 = read two real words after the dummy word.
- busy_o out 1: transaction in progress.
- write_ok_o out 1: 1-cycle pulse when any write completes.
- write_color_ok_o out 1: 1-cycle pulse when a write with rs=1 completes.
- rdata_o out 32: read result.
- rdata_valid_o out 1: 1-cycle pulse when rdata_o is updated.
- lcd_cs_n out 1: chip select, active low.
- lcd_rs out 1: register select.
- lcd_wr_n out 1: write strobe, active low.
- lcd_rd_n out 1: read strobe, active low.
- lcd_data_o out 16: bus data out.
- lcd_data_oe out 1: 1 = drive the data bus.
- lcd_data_i in 16: bus data in.

Behaviour:
- Reset (rst_n=0 at a pclk edge) forces: IDLE, cs_n=1, wr_n=1, rd_n=1, lcd_rs=1, data_oe=0, lcd_data_o=0, busy_o=0, all pulses 0, rdata_o=0.
- Reset mid-transaction aborts the transfer. No ok or valid pulse is generated; the bus returns to idle levels on the next edge.
- All outputs are registered. busy_o=1 exactly while state != IDLE.
- Accept rule: we_i=1 in IDLE latches data_i, wr_i, rs_i, id_fm_i and read_color_i at that edge.
- A we_i pulse while busy_o=1 is ignored and produces no side effect.
- States:
  - IDLE
  - WR_LOW
  - WR_HIGH
  - RD_LOW
  - RD_HIGH
- Write path (IDLE -> WR_LOW -> WR_HIGH -> IDLE):
  - From the cycle after accept: cs_n=0, lcd_rs=latched rs, data_oe=1, lcd_data_o=latched data.
  - wr_n=0 for WR_LOW_CYC cycles, then wr_n=1 for WR_HIGH_CYC cycles. Data stays stable across the wr_n rising edge.
  - On return to IDLE: cs_n=1, data_oe=0, write_ok_o=1 for one cycle. write_color_ok_o=1 in the same cycle if rs=1.
  - busy_o high for WR_LOW_CYC+WR_HIGH_CYC cycles.
- Read path:
  - data_oe=0 throughout; cs_n=0 from the cycle after accept.
  - Word count N = 2 if read_color=0, 3 if read_color=1. Word 0 is the dummy word and is discarded.
  - Per word: RD_LOW then RD_HIGH. RD_LOW lasts RD_LOW_ID or RD_LOW_FM cycles, selected by the latched id_fm.
  - lcd_data_i is sampled at the edge that ends RD_LOW (the same edge that raises rd_n).
  - After RD_HIGH of word k: if k < N-1, go to RD_LOW of word k+1; otherwise go to IDLE.
  - Word 1 is stored in rdata_o[31:16]. Word 2 is stored in rdata_o[15:0]; rdata_o[15:0]=0 when N=2.
  - rdata_valid_o pulses on the first IDLE cycle. rdata_o holds its value until the next read completes.
- Phase counter: 8-bit, loads length-1 on phase entry and decrements to 0. Word counter: 2-bit.
- lcd_rs holds the latched rs_i value until the next accept. It is not changed at the end of a transaction.

Decomposition:
- lcd_pkg holds:
  - the state enum lcd_phy_state_t (IDLE, WR_LOW, WR_HIGH, RD_LOW, RD_HIGH);
  - constants LCD_DW=16 and LCD_CNT_W=8;
  - read word-count constants RD_WORDS_ID=2 and RD_WORDS_COLOR=3.
- One sub-module, lcd_phase_timer: loadable down-counter with a `done` flag, reused for every phase.

Test Plan:
1. Defaults, write command: we_i=1, wr_i=1, rs_i=0, data_i=16'h002C.
   - wr_n low in cycles 1-2, high in cycles 3-4; data=002C and cs_n=0 in cycles 1-4.
   - Cycle 5: cs_n=1, write_ok_o=1, write_color_ok_o=0, busy_o=0.
2. Pixel write: rs_i=1, data_i=16'hF800 -> write_ok_o=1 and write_color_ok_o=1 in the same cycle; lcd_rs=1 throughout.
3. ID read (id_fm=0, read_color=0), bus returns 16'hFFFF for the dummy word and 16'h9341 for word 1.
   - Two rd_n low pulses of 2 cycles each.
   - rdata_o=32'h9341_0000, rdata_valid_o=1; busy_o high for 8 cycles.
4. Color read (id_fm=1, read_color=1), words 16'hXXXX, 16'hF800, 16'h1F00.
   - Three rd_n low pulses of 8 cycles each.
   - rdata_o=32'hF800_1F00; data_oe=0 throughout.
5. we_i pulsed mid-write with data 16'hAAAA -> ignored: only one transaction occurs and the bus never carries AAAA.
6. rst_n=0 during the WR_LOW of a write -> next edge: wr_n=1, cs_n=1, data_oe=0, busy_o=0, and no write_ok_o pulse ever appears.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the 8080-style LCD bus engine.
// Ports: none (package only).
// Holds the phy state encoding, bus/counter widths and read word counts.
package lcd_pkg;

    localparam int LCD_DW         = 16;
    localparam int LCD_CNT_W      = 8;
    // Reads always start with one dummy word that the panel returns first.
    localparam int RD_WORDS_ID    = 2;
    localparam int RD_WORDS_COLOR = 3;

    typedef enum logic [2:0] {
        IDLE,
        WR_LOW,
        WR_HIGH,
        RD_LOW,
        RD_HIGH
    } lcd_phy_state_t;

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times one strobe phase of the LCD bus.
// Ports: pclk/rst_n, load_i + load_val_i (length-1 of the phase), done_o.
// done_o is high while the count is zero, i.e. during the last cycle of a phase.
module lcd_phase_timer
    import lcd_pkg::*;
(
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [LCD_CNT_W-1:0] load_val_i,
    output logic                 done_o
);

    logic [LCD_CNT_W-1:0] cnt_q;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_phy.sv
// 8080-style parallel bus engine for a 16-bit LCD: single-word writes, dummy+1/2 word reads.
// Ports: command side (we/wr/rs/id_fm/read_color/data in; busy/ok pulses/rdata out),
//        panel side (cs_n/rs/wr_n/rd_n strobes, lcd_data_o/oe out, lcd_data_i in).
module lcd_bus_phy
    import lcd_pkg::*;
#(
    parameter int unsigned WR_LOW_CYC  = 2,
    parameter int unsigned WR_HIGH_CYC = 2,
    parameter int unsigned RD_LOW_ID   = 2,
    parameter int unsigned RD_LOW_FM   = 8,
    parameter int unsigned RD_HIGH_CYC = 2
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic [LCD_DW-1:0] data_i,
    input  logic              we_i,
    input  logic              wr_i,
    input  logic              rs_i,
    input  logic              id_fm_i,
    input  logic              read_color_i,
    output logic              busy_o,
    output logic              write_ok_o,
    output logic              write_color_ok_o,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid_o,
    output logic              lcd_cs_n,
    output logic              lcd_rs,
    output logic              lcd_wr_n,
    output logic              lcd_rd_n,
    output logic [LCD_DW-1:0] lcd_data_o,
    output logic              lcd_data_oe,
    input  logic [LCD_DW-1:0] lcd_data_i
);

    localparam logic [LCD_CNT_W-1:0] WR_LOW_LD  = LCD_CNT_W'(WR_LOW_CYC - 1);
    localparam logic [LCD_CNT_W-1:0] WR_HIGH_LD = LCD_CNT_W'(WR_HIGH_CYC - 1);
    localparam logic [LCD_CNT_W-1:0] RD_ID_LD   = LCD_CNT_W'(RD_LOW_ID - 1);
    localparam logic [LCD_CNT_W-1:0] RD_FM_LD   = LCD_CNT_W'(RD_LOW_FM - 1);
    localparam logic [LCD_CNT_W-1:0] RD_HIGH_LD = LCD_CNT_W'(RD_HIGH_CYC - 1);

    lcd_phy_state_t       state_q, state_d;
    logic                 accept;
    logic                 tmr_load, tmr_done;
    logic [LCD_CNT_W-1:0] tmr_val;
    logic                 sel_fm;
    logic                 last_word;

    // Latched request fields and read datapath.
    logic                 id_fm_q;
    logic [1:0]           last_idx_q;
    logic [1:0]           wcnt_q;
    logic [LCD_DW-1:0]    rbuf_hi_q, rbuf_lo_q;

    // Registered outputs.
    logic              cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
    logic              oe_q, oe_d, rs_q, rs_d, busy_q, busy_d;
    logic              wok_q, wok_d, wcok_q, wcok_d, valid_q, valid_d;
    logic [LCD_DW-1:0] dout_q, dout_d;
    logic [31:0]       rdata_q, rdata_d;

    assign accept    = (state_q == IDLE) && we_i;
    assign last_word = (wcnt_q == last_idx_q);
    // The read phase length must come from the live input on the accept edge.
    assign sel_fm    = (state_q == IDLE) ? id_fm_i : id_fm_q;

    // State register
    always_ff @(posedge pclk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (we_i)     state_d = wr_i ? WR_LOW : RD_LOW;
            WR_LOW:  if (tmr_done) state_d = WR_HIGH;
            WR_HIGH: if (tmr_done) state_d = IDLE;
            RD_LOW:  if (tmr_done) state_d = RD_HIGH;
            RD_HIGH: if (tmr_done) state_d = last_word ? IDLE : RD_LOW;
            default:               state_d = IDLE;
        endcase
    end

    // Every transition enters a new phase, so the timer reloads on any state change.
    always_comb begin
        tmr_load = (state_d != state_q) && (state_d != IDLE);
        case (state_d)
            WR_LOW:  tmr_val = WR_LOW_LD;
            WR_HIGH: tmr_val = WR_HIGH_LD;
            RD_LOW:  tmr_val = sel_fm ? RD_FM_LD : RD_ID_LD;
            RD_HIGH: tmr_val = RD_HIGH_LD;
            default: tmr_val = '0;
        endcase
    end

    lcd_phase_timer u_timer (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Output logic: strobe levels follow the state being entered.
    always_comb begin
        cs_n_d  = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        wr_n_d  = (state_d != WR_LOW);
        rd_n_d  = (state_d != RD_LOW);
        oe_d    = (state_d == WR_LOW) || (state_d == WR_HIGH);
        dout_d  = dout_q;
        rs_d    = rs_q;
        if (accept) begin
            rs_d = rs_i;
            if (wr_i) dout_d = data_i;
        end
        wok_d   = (state_q == WR_HIGH) && tmr_done;
        wcok_d  = wok_d && rs_q;
        valid_d = (state_q == RD_HIGH) && tmr_done && last_word;
        rdata_d = valid_d ? {rbuf_hi_q, rbuf_lo_q} : rdata_q;
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            rs_q    <= 1'b1;
            busy_q  <= 1'b0;
            wok_q   <= 1'b0;
            wcok_q  <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
            rdata_q <= '0;
        end else begin
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            rd_n_q  <= rd_n_d;
            oe_q    <= oe_d;
            rs_q    <= rs_d;
            busy_q  <= busy_d;
            wok_q   <= wok_d;
            wcok_q  <= wcok_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
        end
    end

    // Read datapath: word 0 is the dummy and is never stored.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            id_fm_q    <= 1'b0;
            last_idx_q <= 2'd0;
            wcnt_q     <= 2'd0;
            rbuf_hi_q  <= '0;
            rbuf_lo_q  <= '0;
        end else begin
            if (accept) begin
                id_fm_q    <= id_fm_i;
                last_idx_q <= read_color_i ? 2'(RD_WORDS_COLOR - 1) : 2'(RD_WORDS_ID - 1);
                wcnt_q     <= 2'd0;
                rbuf_lo_q  <= '0;
            end
            if ((state_q == RD_HIGH) && (state_d == RD_LOW)) begin
                wcnt_q <= wcnt_q + 2'd1;
            end
            // Sample on the edge that ends the low phase (rd_n rising edge).
            if ((state_q == RD_LOW) && tmr_done) begin
                if (wcnt_q == 2'd1)      rbuf_hi_q <= lcd_data_i;
                else if (wcnt_q == 2'd2) rbuf_lo_q <= lcd_data_i;
            end
        end
    end

    assign busy_o           = busy_q;
    assign write_ok_o       = wok_q;
    assign write_color_ok_o = wcok_q;
    assign rdata_o          = rdata_q;
    assign rdata_valid_o    = valid_q;
    assign lcd_cs_n         = cs_n_q;
    assign lcd_rs           = rs_q;
    assign lcd_wr_n         = wr_n_q;
    assign lcd_rd_n         = rd_n_q;
    assign lcd_data_o       = dout_q;
    assign lcd_data_oe      = oe_q;

endmodule
